// File: rtl/skyline_layer_if.sv
// ============================================================================
// Module      : skyline_layer_if
// Description : Timing-in / layer-out bundle between the VGA sync generator,
//               one skyline layer and the colour/priority mixer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface skyline_layer_if;
    // timing from the sync generator
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       visible;
    logic       line_start;
    logic       frame_start;
    // layer outputs towards the mixer
    logic       pix_on;
    logic [3:0] col_top;
    logic       col_edge;
    logic       win_on;

    // timing source side
    modport master (
        output hcount, vcount, visible, line_start, frame_start,
        input  pix_on, col_top, col_edge, win_on
    );

    // skyline layer side
    modport slave (
        input  hcount, vcount, visible, line_start, frame_start,
        output pix_on, col_top, col_edge, win_on
    );
endinterface

`default_nettype wire

// File: rtl/skyline_layer.sv
// ============================================================================
// Module      : skyline_layer
// Description : One parallax city-skyline layer. A 9-bit LFSR supplies one
//               column height per 2^COL_SHIFT pixels; the pattern scrolls
//               SPEED pixels per frame. A per-line height cutoff ("band")
//               grows every 2^ROW_SHIFT lines below HORIZON. All outputs are
//               registered with one cycle of latency.
//               Optional lit-window pattern: define SKYLINE_WINDOWS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skyline_layer #(
    parameter int         COL_SHIFT = 3,
    parameter int         SPEED     = 1,
    parameter int         HORIZON   = 128,
    parameter int         ROW_SHIFT = 4,
    parameter logic [8:0] SEED      = 9'h1ff
) (
    input  wire logic          clk,
    input  wire logic          rst,
    skyline_layer_if.slave     bus
);

    localparam int                 PH_W      = COL_SHIFT;
    localparam logic [PH_W-1:0]    PH_LAST   = '1;
    localparam logic [PH_W-1:0]    PH_ONE    = PH_W'(1);
    localparam logic [PH_W:0]      SPEED_V   = (PH_W+1)'(SPEED);
    localparam logic [9:0]         HORIZON_V = 10'(HORIZON);
    localparam logic [4:0]         BAND_MAX  = 5'd16;

    // Fibonacci step shared by the frame and line generators.
    function automatic logic [8:0] lfsr_step(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    logic [8:0]      frame_lfsr_q, frame_lfsr_d;
    logic [8:0]      line_lfsr_q,  line_lfsr_d;
    logic [PH_W-1:0] frame_phase_q, frame_phase_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [4:0]      band_q, band_d;
    logic            pix_on_q, pix_on_d;
    logic [3:0]      col_top_q, col_top_d;
    logic            col_edge_q, col_edge_d;

    logic [PH_W:0]      phase_sum;
    logic [ROW_SHIFT-1:0] row_off;
    logic               row_hit;

    // hcount is part of the timing bundle but the column position is tracked
    // by the phase counter, so the layer never looks at it.
    logic unused_inputs;
    assign unused_inputs = ^bus.hcount;

    assign phase_sum = {1'b0, frame_phase_q} + SPEED_V;
    // Low bits of (vcount - HORIZON) only depend on the low bits of each.
    assign row_off   = bus.vcount[ROW_SHIFT-1:0] - HORIZON_V[ROW_SHIFT-1:0];
    assign row_hit   = (row_off == '0);

    // Per-frame scroll: advance the sub-column phase, carry into the LFSR.
    always_comb begin
        frame_phase_d = frame_phase_q;
        frame_lfsr_d  = frame_lfsr_q;
        if (bus.frame_start) begin
            frame_phase_d = phase_sum[PH_W-1:0];
            if (phase_sum[PH_W]) begin
                frame_lfsr_d = lfsr_step(frame_lfsr_q);
            end
        end
    end

    // Height cutoff: cleared above the horizon, grows one unit per storey
    // below it; a frame start always clears it.
    always_comb begin
        band_d = band_q;
        if (bus.frame_start) begin
            band_d = '0;
        end else if (bus.line_start) begin
            if (bus.vcount < HORIZON_V) begin
                band_d = '0;
            end else if (row_hit) begin
                band_d = (band_q >= BAND_MAX) ? BAND_MAX : band_q + 5'd1;
            end
        end
    end

    // Line walker: reload from the frame state at line start (pre-update
    // values), otherwise step the column LFSR on the last pixel of a column.
    always_comb begin
        line_lfsr_d = line_lfsr_q;
        phase_d     = phase_q;
        if (bus.line_start) begin
            line_lfsr_d = frame_lfsr_q;
            phase_d     = frame_phase_q;
        end else if (bus.visible) begin
            phase_d = phase_q + PH_ONE;
            if (phase_q == PH_LAST) begin
                line_lfsr_d = lfsr_step(line_lfsr_q);
            end
        end
    end

    // Pixel outputs, forced low outside active video.
    always_comb begin
        pix_on_d   = bus.visible && ({1'b0, line_lfsr_q[3:0]} < band_q);
        col_top_d  = bus.visible ? line_lfsr_q[3:0] : 4'd0;
        col_edge_d = bus.visible && (phase_q == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_lfsr_q  <= SEED;
            line_lfsr_q   <= SEED;
            frame_phase_q <= '0;
            phase_q       <= '0;
            band_q        <= '0;
            pix_on_q      <= 1'b0;
            col_top_q     <= 4'd0;
            col_edge_q    <= 1'b0;
        end else begin
            frame_lfsr_q  <= frame_lfsr_d;
            line_lfsr_q   <= line_lfsr_d;
            frame_phase_q <= frame_phase_d;
            phase_q       <= phase_d;
            band_q        <= band_d;
            pix_on_q      <= pix_on_d;
            col_top_q     <= col_top_d;
            col_edge_q    <= col_edge_d;
        end
    end

    assign bus.pix_on   = pix_on_q;
    assign bus.col_top  = col_top_q;
    assign bus.col_edge = col_edge_q;

`ifdef SKYLINE_WINDOWS_EN
    logic win_on_q, win_on_d;

    // Lit windows: checkerboard inside buildings, flipped per column and storey.
    always_comb begin
        win_on_d = pix_on_d && phase_q[0] && bus.vcount[1] && (phase_q != '0)
                   && (line_lfsr_q[4] ^ bus.vcount[ROW_SHIFT]);
    end

    // Window register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_on_q <= 1'b0;
        end else begin
            win_on_q <= win_on_d;
        end
    end

    assign bus.win_on = win_on_q;
`else
    assign bus.win_on = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_skyline_layer.sv
// ============================================================================
// Module      : tb_skyline_layer
// Description : Directed self-checking bench for skyline_layer. Two layers,
//               SPEED=0 and SPEED=3, share one timing stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_skyline_layer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    skyline_layer_if sif0 ();
    skyline_layer_if sif3 ();

    skyline_layer #(.COL_SHIFT(3), .SPEED(0), .HORIZON(128), .ROW_SHIFT(4), .SEED(9'h1ff))
        dut0 (.clk(clk), .rst(rst), .bus(sif0.slave));
    skyline_layer #(.COL_SHIFT(3), .SPEED(3), .HORIZON(128), .ROW_SHIFT(4), .SEED(9'h1ff))
        dut3 (.clk(clk), .rst(rst), .bus(sif3.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int band_exp = 0;

    // LFSR sequence from 0x1ff, hand-stepped: one entry per column.
    logic [8:0] lf_tab [0:10] = '{9'h1ff, 9'h1fe, 9'h1fc, 9'h1f8, 9'h1f0, 9'h1e0,
                                  9'h1c1, 9'h183, 9'h107, 9'h00f, 9'h01e};

    task automatic chk(input string tag, input int v, input int h,
                       input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s v=%0d h=%0d observed=%0h expected=%0h", tag, v, h, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int h, input int v, input bit vis, input bit ls, input bit fs);
        sif0.hcount = 10'(h); sif0.vcount = 10'(v); sif0.visible = vis;
        sif0.line_start = ls; sif0.frame_start = fs;
        sif3.hcount = 10'(h); sif3.vcount = 10'(v); sif3.visible = vis;
        sif3.line_start = ls; sif3.frame_start = fs;
    endtask

    // Expected outputs for pixel h of line v, given the line's start phase fp
    // and the index b of its first column in lf_tab.
    task automatic chk_dut(input int d, input int v, input int h, input bit vis,
                           input int fp, input int b);
        int ph, col;
        logic [8:0] lf;
        logic [9:0] vv;
        logic ep, ee, ew;
        logic [3:0] et;
        logic op, oe, ow;
        logic [3:0] ot;
        vv = 10'(v);
        ep = 1'b0; ee = 1'b0; ew = 1'b0; et = 4'd0;
        if (vis) begin
            ph = (fp + h) % 8;
            col = b + (fp + h) / 8;
            lf = lf_tab[col];
            et = lf[3:0];
            ep = (int'(et) < band_exp);
            ee = (ph == 0);
`ifdef SKYLINE_WINDOWS_EN
            ew = ep && (ph % 2 == 1) && vv[1] && (ph != 0) && (lf[4] ^ vv[4]);
`endif
        end
        if (d == 0) begin
            op = sif0.pix_on; oe = sif0.col_edge; ow = sif0.win_on; ot = sif0.col_top;
        end else begin
            op = sif3.pix_on; oe = sif3.col_edge; ow = sif3.win_on; ot = sif3.col_top;
        end
        chk($sformatf("s%0d pix_on", d), v, h, {3'b0, op}, {3'b0, ep});
        chk($sformatf("s%0d col_top", d), v, h, ot, et);
        chk($sformatf("s%0d col_edge", d), v, h, {3'b0, oe}, {3'b0, ee});
        chk($sformatf("s%0d win_on", d), v, h, {3'b0, ow}, {3'b0, ew});
    endtask

    task automatic chk_both(input int v, input int h, input bit vis,
                            input bit c0, input int fp0, input int b0,
                            input bit c3, input int fp3, input int b3);
        if (c0) chk_dut(0, v, h, vis, fp0, b0);
        if (c3) chk_dut(3, v, h, vis, fp3, b3);
    endtask

    // One short scanline: line_start, two blanking cycles, 64 pixels, blank.
    task automatic run_line(input int v, input bit fs,
                            input bit c0, input int fp0, input int b0,
                            input bit c3, input int fp3, input int b3);
        drive(0, v, 1'b0, 1'b1, fs);
        tick();
        if (fs)                                 band_exp = 0;
        else if (v < 128)                       band_exp = 0;
        else if (((v - 128) % 16 == 0) && (band_exp < 16)) band_exp = band_exp + 1;
        chk_both(v, 0, 1'b0, c0, fp0, b0, c3, fp3, b3);
        drive(0, v, 1'b0, 1'b0, 1'b0);
        tick();
        chk_both(v, 0, 1'b0, c0, fp0, b0, c3, fp3, b3);
        for (int h = 0; h < 64; h++) begin
            drive(h, v, 1'b1, 1'b0, 1'b0);
            tick();
            chk_both(v, h, 1'b1, c0, fp0, b0, c3, fp3, b3);
        end
        drive(0, v, 1'b0, 1'b0, 1'b0);
        tick();
        chk_both(v, 64, 1'b0, c0, fp0, b0, c3, fp3, b3);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        // reset state
        chk_both(0, 0, 1'b0, 1'b1, 0, 0, 1'b1, 0, 0);

        // free-running pixels after release start from SEED at phase 0
        rst = 1'b0;
        band_exp = 0;
        for (int h = 0; h < 6; h++) begin
            drive(h, 0, 1'b1, 1'b0, 1'b0);
            tick();
            chk_both(0, h, 1'b1, 1'b1, 0, 0, 1'b1, 0, 0);
        end
        // asynchronous reset mid-line clears outputs before the next edge
        #2 rst = 1'b1;
        #1;
        chk_both(0, 6, 1'b0, 1'b1, 0, 0, 1'b1, 0, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        tick();

        // full frame on the static layer: dark above horizon, bands, saturation
        for (int v = 0; v < 480; v++) begin
            run_line(v, v == 0, 1'b1, 0, 0, 1'b0, 0, 0);
        end

        // frame_start on a horizon line wins over the band increment
        run_line(128, 1'b1, 1'b1, 0, 0, 1'b0, 0, 0);
        run_line(129, 1'b0, 1'b1, 0, 0, 1'b0, 0, 0);

        // scrolling: restart both layers and step through three frames
        rst = 1'b1;
        tick();
        rst = 1'b0;
        band_exp = 0;
        run_line(0, 1'b1, 1'b1, 0, 0, 1'b1, 0, 0);   // reload uses old phase 0
        run_line(1, 1'b0, 1'b1, 0, 0, 1'b1, 3, 0);   // first column 5 px, top f
        run_line(0, 1'b1, 1'b1, 0, 0, 1'b1, 3, 0);
        run_line(1, 1'b0, 1'b1, 0, 0, 1'b1, 6, 0);
        run_line(0, 1'b1, 1'b1, 0, 0, 1'b1, 6, 0);
        run_line(1, 1'b0, 1'b1, 0, 0, 1'b1, 1, 1);   // carry: 7 px, top e

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
